mem_access_arbiter: RTL and testbench

//  Shares the label-checked memory path between two requesters: port 0 is instruction fetch, port 1 is data load/store.

---
 rtl/mem_access_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_arbiter.sv
// Two-port round-robin arbiter in front of the label-checked memory path.
// Port 0 is instruction fetch and port 1 is data load/store.
// Each granted request follows this sequence:
//   1. Look up its label in the LabelTable.
//   2. Check the label type and the offset bounds.
//   3. Run at most one memory transaction.
//   4. Return a one-cycle acknowledge with a fault code and read data.
module mem_access_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int LBID_W = 12,
    parameter int TYPE_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    input  logic [2*LBID_W-1:0] req_lbid,
    input  logic [2*ADDR_W-1:0] req_ofs,
    input  logic [2*TYPE_W-1:0] req_type,
    input  logic [1:0]          req_we,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          rsp_ack,
    output logic [1:0]          rsp_fault,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [LBID_W-1:0]   lbt_lbid,
    input  logic [TYPE_W-1:0]   lbt_typ,
    input  logic [ADDR_W-1:0]   lbt_base,
    input  logic [ADDR_W-1:0]   lbt_count,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        CHECK,
        ACCESS,
        RESP
    } state_t;

    localparam logic [1:0] FAULT_OK      = 2'd0;
    localparam logic [1:0] FAULT_NOLABEL = 2'd1;
    localparam logic [1:0] FAULT_TYPE    = 2'd2;
    localparam logic [1:0] FAULT_BOUNDS  = 2'd3;

    state_t              state;
    state_t              state_nx;
    logic                grant;
    logic                last_grant;
    logic                pick;
    logic [1:0]          fault_c;
    logic [1:0]          fault_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [LBID_W-1:0]   lat_lbid;
    logic [ADDR_W-1:0]   lat_ofs;
    logic [TYPE_W-1:0]   lat_type;
    logic                lat_we;
    logic [DATA_W-1:0]   lat_wdata;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;

    // Arbitration choice, label check result and next-state decode.
    always_comb begin
        state_nx = state;
        pick     = 1'b0;
        fault_c  = FAULT_OK;

        // Both valid: take the port that did not win last time.
        if (req_valid == 2'b11) begin
            pick = ~last_grant;
        end else begin
            pick = req_valid[1];
        end

        // Fault priority: missing label, then wrong type, then out of bounds.
        if (lbt_typ == '0) begin
            fault_c = FAULT_NOLABEL;
        end else if (lbt_typ != lat_type) begin
            fault_c = FAULT_TYPE;
        end else if (lat_ofs >= lbt_count) begin
            fault_c = FAULT_BOUNDS;
        end

        case (state)
            IDLE:    if (|req_valid) state_nx = LOOKUP;
            LOOKUP:  state_nx = CHECK;
            CHECK:   state_nx = (fault_c != FAULT_OK) ? RESP : ACCESS;
            ACCESS:  if (mem_ready) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Request latch, memory interface registers and response capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            lat_lbid    <= '0;
            lat_ofs     <= '0;
            lat_type    <= '0;
            lat_we      <= 1'b0;
            lat_wdata   <= '0;
            fault_q     <= FAULT_OK;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant     <= pick;
                        lat_lbid  <= pick ? req_lbid[2*LBID_W-1:LBID_W] : req_lbid[LBID_W-1:0];
                        lat_ofs   <= pick ? req_ofs[2*ADDR_W-1:ADDR_W]  : req_ofs[ADDR_W-1:0];
                        lat_type  <= pick ? req_type[2*TYPE_W-1:TYPE_W] : req_type[TYPE_W-1:0];
                        lat_we    <= pick ? req_we[1] : req_we[0];
                        lat_wdata <= pick ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
                        fault_q   <= FAULT_OK;
                        rdata_q   <= '0;
                    end
                end
                CHECK: begin
                    fault_q <= fault_c;
                    if (fault_c == FAULT_OK) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= lat_we;
                        mem_addr_q  <= lbt_base + lat_ofs;
                        mem_wdata_q <= lat_wdata;
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (!lat_we) begin
                            rdata_q <= mem_rdata;
                        end
                    end
                end
                RESP: begin
                    last_grant <= grant;
                end
                default: ;
            endcase
        end
    end

    assign rsp_ack   = (state == RESP) ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_fault = (state == RESP) ? fault_q : FAULT_OK;
    assign rsp_rdata = (state == RESP) ? rdata_q : '0;
    assign lbt_lbid  = lat_lbid;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter.
// Contains a LabelTable model with a registered read, a memory model with a
// programmable ready delay, and a scoreboard of expected acknowledges.
module tb_mem_access_arbiter;

    localparam logic [7:0] CODE = 8'h01;
    localparam logic [7:0] DATA = 8'h02;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [23:0] req_lbid = '0;
    logic [31:0] req_ofs = '0;
    logic [15:0] req_type = '0;
    logic [1:0]  req_we = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  rsp_ack;
    logic [1:0]  rsp_fault;
    logic [31:0] rsp_rdata;
    logic [11:0] lbt_lbid;
    logic [7:0]  lbt_typ = '0;
    logic [15:0] lbt_base = '0;
    logic [15:0] lbt_count = '0;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;

    mem_access_arbiter #(.DATA_W(32), .ADDR_W(16), .LBID_W(12), .TYPE_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_lbid(req_lbid),
        .req_ofs(req_ofs), .req_type(req_type), .req_we(req_we), .req_wdata(req_wdata),
        .rsp_ack(rsp_ack), .rsp_fault(rsp_fault), .rsp_rdata(rsp_rdata),
        .lbt_lbid(lbt_lbid), .lbt_typ(lbt_typ), .lbt_base(lbt_base), .lbt_count(lbt_count),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // LabelTable model: one-cycle registered read.
    logic [7:0]  tbl_typ   [0:4095];
    logic [15:0] tbl_base  [0:4095];
    logic [15:0] tbl_count [0:4095];

    always @(posedge clk) begin
        lbt_typ   <= tbl_typ[lbt_lbid];
        lbt_base  <= tbl_base[lbt_lbid];
        lbt_count <= tbl_count[lbt_lbid];
    end

    // Memory model: ready after ready_delay wait cycles of a held request.
    logic [31:0] mem [0:65535];
    int ready_delay = 0;
    int wait_cnt = 0;

    assign mem_ready = mem_req && (wait_cnt >= ready_delay);
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (!mem_req || mem_ready) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
        if (mem_req && mem_ready && mem_we) mem[mem_addr] <= mem_wdata;
    end

    function automatic logic [31:0] pat(input logic [15:0] a);
        return {16'hC0DE, a};
    endfunction

    // Scoreboard.
    typedef struct {
        int          port;
        logic [1:0]  fault;
        logic [31:0] rdata;
        logic [15:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          mem_cycles;
        int          lat;
        int          issue;
    } exp_t;

    exp_t sb[$];

    logic        prev_req = 1'b0;
    logic [1:0]  prev_ack = 2'b00;
    logic [15:0] cap_addr;
    logic        cap_we;
    logic [31:0] cap_wdata;
    logic        unstable = 1'b0;
    int          mcnt = 0;

    // Monitor: tracks the memory request and checks each acknowledge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_req = 1'b0;
            prev_ack = 2'b00;
            unstable = 1'b0;
            mcnt = 0;
        end else begin
            if (mem_req) begin
                if (!prev_req) begin
                    cap_addr  = mem_addr;
                    cap_we    = mem_we;
                    cap_wdata = mem_wdata;
                end else if (mem_addr !== cap_addr || mem_we !== cap_we || mem_wdata !== cap_wdata) begin
                    unstable = 1'b1;
                end
                mcnt++;
            end
            prev_req = mem_req;
            if (rsp_ack != 2'b00) begin
                chk("ack_one_cycle", {62'd0, prev_ack}, 64'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_ack", {62'd0, rsp_ack}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ack_port", {62'd0, rsp_ack}, (e.port == 1) ? 64'd2 : 64'd1);
                    chk("fault", {62'd0, rsp_fault}, {62'd0, e.fault});
                    chk("rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
                    chk("mem_cycles", 64'(mcnt), 64'(e.mem_cycles));
                    if (e.mem_cycles > 0) begin
                        chk("mem_addr", {48'd0, cap_addr}, {48'd0, e.addr});
                        chk("mem_we", {63'd0, cap_we}, {63'd0, e.we});
                        if (e.we) chk("mem_wdata", {32'd0, cap_wdata}, {32'd0, e.wdata});
                        chk("mem_stable", {63'd0, unstable}, 64'd0);
                    end
                    if (e.lat >= 0) chk("latency", 64'(cyc - e.issue), 64'(e.lat));
                end
                mcnt = 0;
                unstable = 1'b0;
            end
            prev_ack = rsp_ack;
        end
    end

    typedef struct {
        int          port;
        logic [11:0] lbid;
        logic [15:0] ofs;
        logic [7:0]  typ;
        logic        we;
        logic [31:0] wdata;
        int          delay;
        logic [1:0]  fault;
        logic [31:0] rdata;
        logic [15:0] addr;
    } vec_t;

    function automatic vec_t mkv(input int port, input logic [11:0] lbid, input logic [15:0] ofs,
                                 input logic [7:0] typ, input logic we, input logic [31:0] wdata,
                                 input int delay, input logic [1:0] fault, input logic [31:0] rdata,
                                 input logic [15:0] addr);
        vec_t v;
        v.port = port; v.lbid = lbid; v.ofs = ofs; v.typ = typ; v.we = we; v.wdata = wdata;
        v.delay = delay; v.fault = fault; v.rdata = rdata; v.addr = addr;
        return v;
    endfunction

    task automatic set_port(input int p, input logic [11:0] lbid, input logic [15:0] ofs,
                            input logic [7:0] typ, input logic we, input logic [31:0] wdata);
        req_lbid[p*12 +: 12]  = lbid;
        req_ofs[p*16 +: 16]   = ofs;
        req_type[p*8 +: 8]    = typ;
        req_we[p]             = we;
        req_wdata[p*32 +: 32] = wdata;
    endtask

    function automatic exp_t mke(input vec_t v, input int lat_check);
        exp_t e;
        e.port = v.port; e.fault = v.fault; e.rdata = v.rdata; e.addr = v.addr;
        e.we = v.we; e.wdata = v.wdata;
        e.mem_cycles = (v.fault != 2'd0) ? 0 : v.delay + 1;
        e.lat = !lat_check ? -1 : ((v.fault != 2'd0) ? 3 : 4 + v.delay);
        e.issue = cyc;
        return e;
    endfunction

    // Wait at negedges for an acknowledge; drops valid early if asked.
    task automatic wait_ack(input int drop_after);
        bit got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (i == drop_after) req_valid = 2'b00;
            if (rsp_ack != 2'b00) got = 1;
        end
        req_valid = 2'b00;
        if (!got) begin
            chk("ack_timeout", 64'd0, 64'd1);
            sb.delete();
        end
    endtask

    task automatic run_vec(input vec_t v, input int drop_after);
        ready_delay = v.delay;
        set_port(v.port, v.lbid, v.ofs, v.typ, v.we, v.wdata);
        sb.push_back(mke(v, 1));
        req_valid[v.port] = 1'b1;
        wait_ack(drop_after);
        @(negedge clk);
    endtask

    function automatic logic [63:0] outs_or();
        return {62'd0, |rsp_ack, |rsp_fault} | {32'd0, rsp_rdata} | {52'd0, lbt_lbid}
             | {63'd0, mem_req} | {63'd0, mem_we} | {48'd0, mem_addr} | {32'd0, mem_wdata}
             | {63'd0, busy};
    endfunction

    vec_t vecs[12];

    initial begin
        for (int i = 0; i < 4096; i++) begin
            tbl_typ[i] = '0; tbl_base[i] = '0; tbl_count[i] = '0;
        end
        tbl_typ[3] = CODE; tbl_base[3] = 16'd2;      tbl_count[3] = 16'd6;
        tbl_typ[5] = DATA; tbl_base[5] = 16'hFFFE;   tbl_count[5] = 16'd8;
        tbl_typ[7] = DATA; tbl_base[7] = 16'h0100;   tbl_count[7] = 16'd0;
        tbl_typ[9] = DATA; tbl_base[9] = 16'h0020;   tbl_count[9] = 16'd16;
        for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));

        vecs[0]  = mkv(0, 12'd3, 16'd2,   CODE, 1'b0, 32'd0,         0, 2'd0, pat(16'd4),     16'd4);
        vecs[1]  = mkv(0, 12'd3, 16'd6,   CODE, 1'b0, 32'd0,         0, 2'd3, 32'd0,          16'd0);
        vecs[2]  = mkv(0, 12'd3, 16'd5,   CODE, 1'b0, 32'd0,         0, 2'd0, pat(16'd7),     16'd7);
        vecs[3]  = mkv(1, 12'd0, 16'd0,   DATA, 1'b0, 32'd0,         0, 2'd1, 32'd0,          16'd0);
        vecs[4]  = mkv(1, 12'd3, 16'd0,   DATA, 1'b0, 32'd0,         0, 2'd2, 32'd0,          16'd0);
        vecs[5]  = mkv(0, 12'd0, 16'd100, CODE, 1'b0, 32'd0,         0, 2'd1, 32'd0,          16'd0);
        vecs[6]  = mkv(1, 12'd7, 16'd0,   DATA, 1'b0, 32'd0,         0, 2'd3, 32'd0,          16'd0);
        vecs[7]  = mkv(1, 12'd5, 16'd3,   DATA, 1'b1, 32'hDEADBEEF,  5, 2'd0, 32'd0,          16'h0001);
        vecs[8]  = mkv(0, 12'd5, 16'd3,   DATA, 1'b0, 32'd0,         2, 2'd0, 32'hDEADBEEF,   16'h0001);
        vecs[9]  = mkv(1, 12'd3, 16'd5,   CODE, 1'b0, 32'd0,         1, 2'd0, pat(16'd7),     16'd7);
        vecs[10] = mkv(1, 12'd9, 16'd15,  DATA, 1'b0, 32'd0,         0, 2'd0, pat(16'h002F),  16'h002F);
        vecs[11] = mkv(1, 12'd9, 16'd16,  DATA, 1'b0, 32'd0,         0, 2'd3, 32'd0,          16'd0);

        // Power-on reset: every output low.
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs_or(), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i], -1);

        // Valid dropped one cycle after issue: the transaction still completes.
        run_vec(mkv(0, 12'd9, 16'd2, DATA, 1'b0, 32'd0, 3, 2'd0, pat(16'h0022), 16'h0022), 0);

        // Reset during ACCESS: abandon with no acknowledge.
        ready_delay = 20;
        set_port(1, 12'd9, 16'd3, DATA, 1'b0, 32'd0);
        req_valid = 2'b10;
        begin
            bit seen = 0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                if (mem_req) seen = 1;
            end
            chk("reset_mid_reached_access", {63'd0, seen}, 64'd1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        chk("reset_mid_outputs", outs_or(), 64'd0);
        rst_n = 1'b1;
        ready_delay = 0;
        repeat (8) @(negedge clk);
        chk("reset_mid_idle", {63'd0, busy}, 64'd0);

        // Both ports held valid: strict alternation starting at port 0.
        set_port(0, 12'd3, 16'd1, CODE, 1'b0, 32'd0);
        set_port(1, 12'd9, 16'd4, DATA, 1'b0, 32'd0);
        for (int k = 0; k < 4; k++) begin
            vec_t v;
            v = (k % 2 == 0) ? mkv(0, 12'd3, 16'd1, CODE, 1'b0, 32'd0, 0, 2'd0, pat(16'd3), 16'd3)
                             : mkv(1, 12'd9, 16'd4, DATA, 1'b0, 32'd0, 0, 2'd0, pat(16'h0024), 16'h0024);
            sb.push_back(mke(v, (k == 0) ? 1 : 0));
        end
        req_valid = 2'b11;
        begin
            int acks = 0;
            for (int i = 0; i < 80 && acks < 4; i++) begin
                @(negedge clk);
                if (rsp_ack != 2'b00) acks++;
            end
            req_valid = 2'b00;
            chk("alternation_ack_count", 64'(acks), 64'd4);
        end
        repeat (8) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
